// File: rtl/adder_reservation_station_pkg.sv
// Shared constants, opcodes and FSM states for the adder reservation station.
package adder_reservation_station_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_RB_SIZE   = 8;
    localparam int DEF_RB_INDEX  = 4;
    localparam int DEF_FU_INDEX  = 4;
    localparam int DEF_READY     = 15;

    localparam int ADDER_START = 0;
    localparam int ADDER_NUM   = 2;

    localparam logic [3:0] NO_FU = 4'hF;

    typedef enum logic [3:0] {
        INST_ADD  = 4'h1,
        INST_SUB  = 4'h2,
        INST_ADDI = 4'h3,
        INST_SUBI = 4'h4
    } opcode_e;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT_OPS,
        RS_EXEC,
        RS_BCAST
    } rs_state_e;

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == INST_ADDI) || (op == INST_SUBI);
    endfunction

endpackage

// File: rtl/adder_reservation_station_rs_alu.sv
// Combinational adder/subtractor; unknown opcodes produce zero.
module rs_alu
    import adder_reservation_station_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic [3:0]           op_i,
    input  logic [WORD_SIZE-1:0] j_i,
    input  logic [WORD_SIZE-1:0] k_i,
    output logic [WORD_SIZE-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            INST_ADD, INST_ADDI: result_o = j_i + k_i;
            INST_SUB, INST_SUBI: result_o = j_i - k_i;
            default:             result_o = '0;
        endcase
    end

endmodule

// File: rtl/adder_reservation_station.sv
// Single-entry reservation station for one adder unit: issue, operand snoop,
// fixed-latency execute, then a one-cycle broadcast on the owning ROB lane.
module adder_reservation_station
    import adder_reservation_station_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int RB_SIZE     = DEF_RB_SIZE,
    parameter int RB_INDEX    = DEF_RB_INDEX,
    parameter int READY       = DEF_READY,
    parameter int FU_INDEX    = DEF_FU_INDEX,
    parameter int FU_ID       = ADDER_START,
    parameter int ADD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FU_INDEX-1:0]          CDB_inst_fu,
    input  logic [WORD_SIZE-1:0]         CDB_inst_inst,
    input  logic [RB_INDEX-1:0]          CDB_inst_RBindex,
    input  logic [WORD_SIZE-1:0]         vj,
    input  logic [WORD_SIZE-1:0]         vk,
    input  logic [RB_INDEX-1:0]          qj,
    input  logic [RB_INDEX-1:0]          qk,
    input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_in,
    input  logic [RB_SIZE-1:0]           CDB_data_valid_in,
    output logic                         busy,
    output logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_out,
    output logic [RB_SIZE-1:0]           CDB_data_valid_out
);

    localparam int CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [RB_INDEX-1:0] READY_TAG = RB_INDEX'(READY);

    rs_state_e              state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [RB_INDEX-1:0]    rb_q, rb_d;
    logic [WORD_SIZE-1:0]   vj_q, vj_d, vk_q, vk_d;
    logic [RB_INDEX-1:0]    qj_q, qj_d, qk_q, qk_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   result_q, result_d;
    logic [WORD_SIZE-1:0]   alu_result;

    logic [3:0]             issue_op;
    logic [12:0]            issue_imm;
    logic [WORD_SIZE-1:0]   imm_sext;
    logic                   issue_acc;
    logic                   unused_inst_bits;

    assign issue_op         = CDB_inst_inst[31:28];
    assign issue_imm        = CDB_inst_inst[12:0];
    assign imm_sext         = {{(WORD_SIZE-13){issue_imm[12]}}, issue_imm};
    assign unused_inst_bits = ^CDB_inst_inst[27:13];

    // The ROB may reissue on the edge that closes the broadcast cycle.
    assign issue_acc = (CDB_inst_fu == FU_INDEX'(FU_ID))
                    && ((state_q == RS_IDLE) || (state_q == RS_BCAST));

    // Tags outside 0..RB_SIZE-1 (including READY) never match a lane.
    function automatic logic snoop_hit(input logic [RB_INDEX-1:0] tag,
                                       input logic [RB_SIZE-1:0]  vld);
        snoop_hit = 1'b0;
        for (int i = 0; i < RB_SIZE; i++) begin
            if ((tag == RB_INDEX'(i)) && vld[i]) snoop_hit = 1'b1;
        end
    endfunction

    function automatic logic [WORD_SIZE-1:0] snoop_val(input logic [RB_INDEX-1:0]          tag,
                                                      input logic [RB_SIZE*WORD_SIZE-1:0] dat);
        snoop_val = '0;
        for (int i = 0; i < RB_SIZE; i++) begin
            if (tag == RB_INDEX'(i)) snoop_val = dat[i*WORD_SIZE +: WORD_SIZE];
        end
    endfunction

    rs_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .op_i     (op_q),
        .j_i      (vj_q),
        .k_i      (vk_q),
        .result_o (alu_result)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rb_d     = rb_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            RS_WAIT_OPS: begin
                if ((qj_q != READY_TAG) && snoop_hit(qj_q, CDB_data_valid_in)) begin
                    vj_d = snoop_val(qj_q, CDB_data_data_in);
                    qj_d = READY_TAG;
                end
                if ((qk_q != READY_TAG) && snoop_hit(qk_q, CDB_data_valid_in)) begin
                    vk_d = snoop_val(qk_q, CDB_data_data_in);
                    qk_d = READY_TAG;
                end
                if ((qj_d == READY_TAG) && (qk_d == READY_TAG)) begin
                    state_d = RS_EXEC;
                    cnt_d   = CW'(ADD_LATENCY - 1);
                end
            end
            RS_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = alu_result;
                    state_d  = RS_BCAST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RS_BCAST: state_d = RS_IDLE;
            default:  state_d = state_q;
        endcase

        if (issue_acc) begin
            op_d = issue_op;
            rb_d = CDB_inst_RBindex;
            vj_d = vj;
            qj_d = qj;
            if (is_imm_op(issue_op)) begin
                vk_d = imm_sext;
                qk_d = READY_TAG;
            end else begin
                vk_d = vk;
                qk_d = qk;
            end
            if ((qj_d != READY_TAG) && snoop_hit(qj_d, CDB_data_valid_in)) begin
                vj_d = snoop_val(qj_d, CDB_data_data_in);
                qj_d = READY_TAG;
            end
            if ((qk_d != READY_TAG) && snoop_hit(qk_d, CDB_data_valid_in)) begin
                vk_d = snoop_val(qk_d, CDB_data_data_in);
                qk_d = READY_TAG;
            end
            if ((qj_d == READY_TAG) && (qk_d == READY_TAG)) begin
                state_d = RS_EXEC;
                cnt_d   = CW'(ADD_LATENCY - 1);
            end else begin
                state_d = RS_WAIT_OPS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RS_IDLE;
            op_q     <= '0;
            rb_q     <= '0;
            vj_q     <= '0;
            vk_q     <= '0;
            qj_q     <= READY_TAG;
            qk_q     <= READY_TAG;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rb_q     <= rb_d;
            vj_q     <= vj_d;
            vk_q     <= vk_d;
            qj_q     <= qj_d;
            qk_q     <= qk_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy = (state_q != RS_IDLE);

    always_comb begin
        CDB_data_data_out  = '0;
        CDB_data_valid_out = '0;
        if (state_q == RS_BCAST) begin
            for (int i = 0; i < RB_SIZE; i++) begin
                if (rb_q == RB_INDEX'(i)) begin
                    CDB_data_valid_out[i]                       = 1'b1;
                    CDB_data_data_out[i*WORD_SIZE +: WORD_SIZE] = result_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_reservation_station.sv
// Bench for adder_reservation_station: directed scenarios plus randomized issues
// checked against an arithmetic model of issue/snoop/latency timing.
module tb_adder_reservation_station;
    import adder_reservation_station_pkg::*;

    localparam int W    = 32;
    localparam int RBS  = 8;
    localparam int RBI  = 4;
    localparam int RDY  = 15;
    localparam int FUI  = 4;
    localparam int FUID = 0;
    localparam int LAT  = 2;

    logic               clk;
    logic               reset;
    logic [FUI-1:0]     inst_fu;
    logic [W-1:0]       inst_inst;
    logic [RBI-1:0]     inst_rb;
    logic [W-1:0]       vj, vk;
    logic [RBI-1:0]     qj, qk;
    logic [RBS*W-1:0]   din;
    logic [RBS-1:0]     vin;
    logic               busy;
    logic [RBS*W-1:0]   dout;
    logic [RBS-1:0]     vout;

    int n_vec = 0;
    int n_err = 0;

    adder_reservation_station #(
        .WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(RBI), .READY(RDY),
        .FU_INDEX(FUI), .FU_ID(FUID), .ADD_LATENCY(LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .CDB_inst_fu       (inst_fu),
        .CDB_inst_inst     (inst_inst),
        .CDB_inst_RBindex  (inst_rb),
        .vj                (vj),
        .vk                (vk),
        .qj                (qj),
        .qk                (qk),
        .CDB_data_data_in  (din),
        .CDB_data_valid_in (vin),
        .busy              (busy),
        .CDB_data_data_out (dout),
        .CDB_data_valid_out(vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        inst_fu   = NO_FU;
        inst_inst = '0;
        inst_rb   = '0;
        vj        = '0;
        vk        = '0;
        qj        = 4'(RDY);
        qk        = 4'(RDY);
        din       = '0;
        vin       = '0;
    endtask

    task automatic drive_issue(input logic [3:0] op, input logic [12:0] imm, input int slot,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input int ta, input int tb_k);
        inst_fu   = 4'(FUID);
        inst_inst = {op, 15'h0, imm};
        inst_rb   = 4'(slot);
        vj        = a;
        vk        = b;
        qj        = 4'(ta);
        qk        = 4'(tb_k);
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
        if (op == INST_ADD || op == INST_ADDI) return j + k;
        if (op == INST_SUB || op == INST_SUBI) return j - k;
        return '0;
    endfunction

    function automatic logic [RBS*W-1:0] lane(input int s, input logic [W-1:0] v);
        logic [RBS*W-1:0] r;
        r = '0;
        r[s*W +: W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] sext13(input logic [12:0] imm);
        return {{(W-13){imm[12]}}, imm};
    endfunction

    task automatic test_reset;
        logic eb;
        reset = 1'b1;
        idle_in();
        drive_issue(INST_ADD, 13'h0, 3, 32'd1, 32'd2, RDY, RDY);
        step();
        step();
        n_vec++;
        if (busy !== 1'b0 || vout !== '0 || dout !== '0) begin
            n_err++;
            $display("FAIL reset_state busy=%b vout=%h dout_nz=%b, required busy=0 vout=00 dout=0",
                     busy, vout, |dout);
        end
        reset = 1'b0;
        idle_in();
        drive_issue(INST_ADD, 13'h0, 3, 32'd1, 32'd2, RDY, RDY);
        inst_fu = 4'(FUID + 1);
        eb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            idle_in();
            n_vec++;
            if (busy !== eb || vout !== '0) begin
                n_err++;
                $display("FAIL other_fu_ignored c=%0d busy=%b vout=%h, required busy=0 vout=00",
                         c, busy, vout);
            end
        end
    endtask

    task automatic test_add_ready;
        logic eb; logic [RBS-1:0] ev; logic [RBS*W-1:0] ed;
        drive_issue(INST_ADD, 13'h0, 3, 32'd5, 32'd7, RDY, RDY);
        for (int c = 0; c <= LAT + 1; c++) begin
            step();
            idle_in();
            eb = (c <= LAT);
            ev = (c == LAT) ? 8'b0000_1000 : 8'h00;
            ed = (c == LAT) ? lane(3, 32'd12) : '0;
            n_vec++;
            if (busy !== eb || vout !== ev || dout !== ed) begin
                n_err++;
                $display("FAIL add_ready c=%0d busy=%b vout=%h lane3=%h, required busy=%b vout=%h lane3=%h",
                         c, busy, vout, dout[3*W +: W], eb, ev, ed[3*W +: W]);
            end
        end
    endtask

    task automatic test_subi_wait;
        logic eb; logic [RBS-1:0] ev; logic [RBS*W-1:0] ed;
        int r;
        r = 2;
        drive_issue(INST_SUBI, 13'h1FFF, 6, 32'hDEAD_BEEF, 32'h1234_5678, 2, 9);
        for (int c = 0; c <= r + LAT + 1; c++) begin
            if (c == 1) begin
                vin = 8'h40;
                din = lane(6, 32'd555);
            end else if (c == r) begin
                vin = 8'h04;
                din = lane(2, 32'd100);
            end
            step();
            idle_in();
            eb = (c <= r + LAT);
            ev = (c == r + LAT) ? 8'h40 : 8'h00;
            ed = (c == r + LAT) ? lane(6, 32'd101) : '0;
            n_vec++;
            if (busy !== eb || vout !== ev || dout !== ed) begin
                n_err++;
                $display("FAIL subi_wait c=%0d busy=%b vout=%h lane6=%h, required busy=%b vout=%h lane6=%h",
                         c, busy, vout, dout[6*W +: W], eb, ev, ed[6*W +: W]);
            end
        end
    endtask

    task automatic test_same_tag;
        logic eb; logic [RBS-1:0] ev; logic [RBS*W-1:0] ed;
        drive_issue(INST_ADD, 13'h0, 1, 32'h1111_1111, 32'h2222_2222, 4, 4);
        vin = 8'h10;
        din = lane(4, 32'hFFFF_FFFF);
        for (int c = 0; c <= LAT + 1; c++) begin
            step();
            idle_in();
            eb = (c <= LAT);
            ev = (c == LAT) ? 8'h02 : 8'h00;
            ed = (c == LAT) ? lane(1, 32'hFFFF_FFFE) : '0;
            n_vec++;
            if (busy !== eb || vout !== ev || dout !== ed) begin
                n_err++;
                $display("FAIL same_tag c=%0d busy=%b vout=%h lane1=%h, required busy=%b vout=%h lane1=%h",
                         c, busy, vout, dout[1*W +: W], eb, ev, ed[1*W +: W]);
            end
        end
    endtask

    task automatic test_flush_wait;
        drive_issue(INST_ADD, 13'h0, 0, 32'd0, 32'd1, 5, RDY);
        for (int c = 0; c < 2; c++) begin
            step();
            idle_in();
            n_vec++;
            if (busy !== 1'b1 || vout !== '0) begin
                n_err++;
                $display("FAIL flush_pre c=%0d busy=%b vout=%h, required busy=1 vout=00", c, busy, vout);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || vout !== '0) begin
            n_err++;
            $display("FAIL flush_edge busy=%b vout=%h, required busy=0 vout=00", busy, vout);
        end
        vin = 8'h20;
        din = lane(5, 32'd7);
        for (int c = 0; c < 4; c++) begin
            step();
            idle_in();
            n_vec++;
            if (busy !== 1'b0 || vout !== '0 || dout !== '0) begin
                n_err++;
                $display("FAIL flush_post c=%0d busy=%b vout=%h dout_nz=%b, required busy=0 vout=00 dout=0",
                         c, busy, vout, |dout);
            end
        end
    endtask

    task automatic test_busy_issue;
        logic eb; logic [RBS-1:0] ev; logic [RBS*W-1:0] ed;
        drive_issue(INST_SUB, 13'h0, 1, 32'd10, 32'd3, RDY, RDY);
        for (int c = 0; c <= LAT + 1; c++) begin
            step();
            idle_in();
            if (c + 1 < LAT) drive_issue(INST_ADD, 13'h0, 5, 32'd100, 32'd100, RDY, RDY);
            eb = (c <= LAT);
            ev = (c == LAT) ? 8'h02 : 8'h00;
            ed = (c == LAT) ? lane(1, 32'd7) : '0;
            n_vec++;
            if (busy !== eb || vout !== ev || dout !== ed) begin
                n_err++;
                $display("FAIL busy_issue c=%0d busy=%b vout=%h lane1=%h, required busy=%b vout=%h lane1=%h",
                         c, busy, vout, dout[1*W +: W], eb, ev, ed[1*W +: W]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic eb; logic [RBS-1:0] ev; logic [RBS*W-1:0] ed;
        drive_issue(INST_ADDI, 13'd5, 0, 32'd20, 32'd999, RDY, 3);
        for (int c = 0; c <= 2 * LAT + 2; c++) begin
            step();
            idle_in();
            if (c == LAT) drive_issue(INST_SUB, 13'h0, 7, 32'd50, 32'd8, RDY, RDY);
            eb = (c <= 2 * LAT + 1);
            ev = (c == LAT) ? 8'h01 : (c == 2 * LAT + 1) ? 8'h80 : 8'h00;
            ed = (c == LAT) ? lane(0, 32'd25) : (c == 2 * LAT + 1) ? lane(7, 32'd42) : '0;
            n_vec++;
            if (busy !== eb || vout !== ev || dout !== ed) begin
                n_err++;
                $display("FAIL back_to_back c=%0d busy=%b vout=%h, required busy=%b vout=%h",
                         c, busy, vout, eb, ev);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] op; logic [12:0] imm;
        logic [W-1:0] jv, kv, vj_in, vk_in, exp_res;
        logic eb; logic [RBS-1:0] ev; logic [RBS*W-1:0] ed;
        int rb, tj, tk, dj, dk, r;
        bit pj, pk;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 4))
                0: op = INST_ADD;
                1: op = INST_SUB;
                2: op = INST_ADDI;
                3: op = INST_SUBI;
                default: op = 4'hC;
            endcase
            rb    = $urandom_range(0, RBS - 1);
            imm   = 13'($urandom);
            jv    = $urandom;
            pj    = $urandom_range(0, 1) == 1;
            tj    = pj ? $urandom_range(0, RBS - 1) : RDY;
            dj    = $urandom_range(0, 3);
            vj_in = pj ? $urandom : jv;
            pk    = 1'b0;
            dk    = 0;
            if (is_imm_op(op)) begin
                kv    = sext13(imm);
                tk    = $urandom_range(0, 15);
                vk_in = $urandom;
            end else begin
                kv    = $urandom;
                pk    = $urandom_range(0, 1) == 1;
                tk    = pk ? $urandom_range(0, RBS - 1) : RDY;
                dk    = $urandom_range(0, 3);
                vk_in = pk ? $urandom : kv;
                if (pj && pk && tj == tk) begin
                    dk = dj;
                    kv = jv;
                end
            end
            r = 0;
            if (pj && dj > r) r = dj;
            if (pk && dk > r) r = dk;
            exp_res = model(op, jv, kv);
            for (int c = 0; c <= r + LAT + 1; c++) begin
                idle_in();
                if (c == 0) begin
                    drive_issue(op, imm, rb, vj_in, vk_in, tj, tk);
                    inst_inst[27:13] = 15'($urandom);
                end else if (c <= r + LAT && $urandom_range(0, 3) == 0) begin
                    drive_issue(4'($urandom), 13'($urandom), $urandom_range(0, RBS - 1),
                                $urandom, $urandom, RDY, RDY);
                end
                vin = 8'($urandom);
                for (int l = 0; l < RBS; l++) din[l*W +: W] = $urandom;
                if (pj) begin
                    if (c < dj) vin[tj] = 1'b0;
                    if (c == dj) begin vin[tj] = 1'b1; din[tj*W +: W] = jv; end
                end
                if (pk) begin
                    if (c < dk) vin[tk] = 1'b0;
                    if (c == dk) begin vin[tk] = 1'b1; din[tk*W +: W] = kv; end
                end
                step();
                eb = (c <= r + LAT);
                ev = (c == r + LAT) ? (8'h01 << rb) : 8'h00;
                ed = (c == r + LAT) ? lane(rb, exp_res) : '0;
                n_vec++;
                if (busy !== eb || vout !== ev || dout !== ed) begin
                    n_err++;
                    $display("FAIL random it=%0d c=%0d op=%h busy=%b vout=%h lane=%h, required busy=%b vout=%h lane=%h",
                             it, c, op, busy, vout, dout[rb*W +: W], eb, ev, exp_res);
                end
            end
            idle_in();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        test_reset();
        test_add_ready();
        test_subi_wait();
        test_same_tag();
        test_flush_wait();
        test_busy_issue();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
